alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RESETN  in  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-004 RUN  in  1  1 = keep fetching instructions; 0 = stop at next instruction boundary.
REQ-005 MEM_RDATA  in  16  memory read data, valid when MEM_ACK=1.
REQ-006 MEM_ACK  in  1  memory completion strobe; ignored while MEM_REQ=0.
REQ-007 ALU_COUT  in  1  carry-out from ALU datapath for the current instruction.
REQ-008 RN_VAL  in  16  Rn register value (jump target for jmr).
REQ-009 ADDR_VAL  in  16  effective address from datapath for ldr/sti/stk.
REQ-010 MEM_REQ  out  1  memory request; held high until MEM_ACK sampled high.
REQ-011 MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ=1.
REQ-012 MEM_ADDR  out  16  memory address; stable while MEM_REQ=1.
REQ-013 INSTR  out  16  instruction register, drives the ALU decoder.
REQ-014 CARRY  out  1  carry flag register, drives the ALU decoder.
REQ-015 REG_WE  out  1  register-file write enable, one-cycle pulse.
REQ-016 PC  out  16  program counter.
REQ-017 STATE  out  3  current FSM state encoding.
REQ-018 HALTED  out  1  1 while in HALT state.

Function
REQ-019 States SHALL be IDLE=0, FETCH=1, EXEC=2, EXEC2=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to IDLE next cycle.
REQ-020 Opcode classes on INSTR[15:11]: ALU = 00001, 0001x, 00100, 00101, 0011x, 01000, 01010, 01011, 01100; MUL = 01001; MEMRD = 01110 (ldr); MEMWR = 01111 (sti); STK = 01101; JMP = 11100; HALT = 11111; all others NOP.
REQ-021 IDLE: all strobes 0; RUN=1 -> FETCH.
REQ-022 FETCH: MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC; on MEM_ACK=1 latch INSTR<=MEM_RDATA, PC<=PC+1 modulo 2^16 (0xFFFF wraps to 0x0000), go EXEC; otherwise remain.
REQ-023 Zero-wait memory SHALL be supported: MEM_ACK high in first FETCH/MEM cycle completes that state in one cycle.
REQ-024 EXEC, ALU class: REG_WE=1 for that cycle, CARRY<=ALU_COUT at the edge, then done.
REQ-025 EXEC, MUL class: no write; go EXEC2; EXEC2: REG_WE=1, CARRY<=ALU_COUT, then done (two execute cycles).
REQ-026 EXEC, MEMRD/MEMWR/STK: latch ADDR_VAL into an address register, go MEM.
REQ-027 MEM: MEM_REQ=1, MEM_ADDR=latched address, MEM_WE=1 for MEMWR or for STK with INSTR[6]=1 (push), else 0; on MEM_ACK: MEMWR -> done; MEMRD and STK -> WB.
REQ-028 WB: REG_WE=1 for one cycle, CARRY unchanged, then done.
REQ-029 EXEC, JMP: PC<=RN_VAL at the edge, then done; EXEC, NOP: done.
REQ-030 EXEC, HALT: go HALT; HALT holds all registers, HALTED=1, exits only via reset.
REQ-031 "Done" SHALL mean next state FETCH if RUN=1, else IDLE; RUN is sampled only at IDLE and at done.
REQ-032 CARRY SHALL change only in REQ-024/REQ-025 cycles; INSTR only at FETCH completion; PC only at FETCH completion or JMP.
REQ-033 MEM_REQ, MEM_WE, REG_WE SHALL be 0 in every state not listed as asserting them.
REQ-034 MEM_ADDR SHALL read 0 when MEM_REQ=0.

Reset
REQ-035 With RESETN=0 at an edge: STATE=IDLE, PC=0x0000, INSTR=0x0000, CARRY=0, address register=0, all strobes 0, HALTED=0, including mid-FETCH/MEM (MEM_REQ drops at that edge; a late MEM_ACK is ignored).

Verification
REQ-036 Reset, RUN=1, memory[0]=0x0800 (adr), ACK zero-wait, ALU_COUT=1 -> FETCH 1 cycle, EXEC REG_WE pulse, CARRY=1, PC=1, back to FETCH.
REQ-037 memory[1]=0x4800 (mlr), ACK after 3 wait cycles -> FETCH lasts 4 cycles, EXEC no REG_WE, EXEC2 REG_WE pulse, CARRY updated once.
REQ-038 INSTR=0x7800 (sti), ADDR_VAL=0x1234 -> MEM with MEM_WE=1, MEM_ADDR=0x1234 stable until ACK, no REG_WE; 0x7000 (ldr) -> MEM_WE=0 then WB REG_WE pulse.
REQ-039 PC=0xFFFF fetch -> PC=0x0000; INSTR=0xE000 (jmr) RN_VAL=0x0040 -> next FETCH MEM_ADDR=0x0040.
REQ-040 INSTR=0xF800 -> HALT, HALTED=1 for 20 cycles regardless of RUN/ACK; RESETN=0 -> IDLE, PC=0.
REQ-041 RUN dropped during MEM wait -> completes instruction then IDLE; RESETN=0 during FETCH wait with later ACK -> IDLE, INSTR stays 0x0000.

Source files
------------

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer: fetch/execute sequencer that drives the ALU decoder and memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_sequencer (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        run_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ack_i,
  input  logic        alu_cout_i,
  input  logic [15:0] rn_val_i,
  input  logic [15:0] addr_val_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] instr_o,
  output logic        carry_o,
  output logic        reg_we_o,
  output logic [15:0] pc_o,
  output logic [2:0]  state_o,
  output logic        halted_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_EXEC2 = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_MUL   = 3'd2,
    C_MEMRD = 3'd3,
    C_MEMWR = 3'd4,
    C_STK   = 3'd5,
    C_JMP   = 3'd6,
    C_HALT  = 3'd7
  } class_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        carry_q, carry_d;
  logic [15:0] addr_q, addr_d;
  class_t      cls;
  state_t      done_state;

  always_comb begin
    cls = C_NOP;
    case (instr_q[15:11]) inside
      5'b00001, 5'b0001?, 5'b00100, 5'b00101, 5'b0011?,
      5'b01000, 5'b01010, 5'b01011, 5'b01100: cls = C_ALU;
      5'b01001: cls = C_MUL;
      5'b01110: cls = C_MEMRD;
      5'b01111: cls = C_MEMWR;
      5'b01101: cls = C_STK;
      5'b11100: cls = C_JMP;
      5'b11111: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  // RUN is only consulted here and in IDLE
  assign done_state = run_i ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    carry_d    = carry_q;
    addr_d     = addr_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 16'h0000;
    reg_we_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q;
        if (mem_ack_i) begin
          instr_d = mem_rdata_i;
          pc_d    = pc_q + 16'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_ALU: begin
            reg_we_o = 1'b1;
            carry_d  = alu_cout_i;
            state_d  = done_state;
          end
          C_MUL: state_d = S_EXEC2;
          C_MEMRD, C_MEMWR, C_STK: begin
            addr_d  = addr_val_i;
            state_d = S_MEM;
          end
          C_JMP: begin
            pc_d    = rn_val_i;
            state_d = done_state;
          end
          C_HALT:  state_d = S_HALT;
          default: state_d = done_state;
        endcase
      end
      S_EXEC2: begin
        reg_we_o = 1'b1;
        carry_d  = alu_cout_i;
        state_d  = done_state;
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        // stack ops write on push (bit 6 set), read on pop
        mem_we_o   = (cls == C_MEMWR) || ((cls == C_STK) && instr_q[6]);
        if (mem_ack_i) state_d = (cls == C_MEMWR) ? done_state : S_WB;
      end
      S_WB: begin
        reg_we_o = 1'b1;
        state_d  = done_state;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      pc_q    <= 16'h0000;
      instr_q <= 16'h0000;
      carry_q <= 1'b0;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      carry_q <= carry_d;
      addr_q  <= addr_d;
    end
  end

  assign instr_o  = instr_q;
  assign carry_o  = carry_q;
  assign pc_o     = pc_q;
  assign state_o  = state_q;
  assign halted_o = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer: directed plus random instruction stream against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int K_NOP = 0, K_ALU = 1, K_MUL = 2, K_MRD = 3, K_MWR = 4, K_STK = 5, K_JMP = 6, K_HLT = 7;

  logic        clk = 1'b0;
  logic        resetn_i, run_i, mem_ack_i, alu_cout_i;
  logic [15:0] mem_rdata_i, rn_val_i, addr_val_i;
  logic        mem_req_o, mem_we_o, carry_o, reg_we_o, halted_o;
  logic [15:0] mem_addr_o, instr_o, pc_o;
  logic [2:0]  state_o;

  int ncmp = 0;
  int nfail = 0;

  logic [15:0] m_pc, m_instr;
  logic        m_carry;

  alu_sequencer dut (
    .clk_i(clk), .resetn_i(resetn_i), .run_i(run_i),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .alu_cout_i(alu_cout_i),
    .rn_val_i(rn_val_i), .addr_val_i(addr_val_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .instr_o(instr_o), .carry_o(carry_o), .reg_we_o(reg_we_o),
    .pc_o(pc_o), .state_o(state_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Opcode classes straight from the instruction-set table
  function automatic int classify(input logic [15:0] ins);
    logic [4:0] op;
    op = ins[15:11];
    if (op == 5'b00001 || op[4:1] == 4'b0001 || op == 5'b00100 || op == 5'b00101 ||
        op[4:1] == 4'b0011 || op == 5'b01000 || op == 5'b01010 || op == 5'b01011 ||
        op == 5'b01100) return K_ALU;
    if (op == 5'b01001) return K_MUL;
    if (op == 5'b01110) return K_MRD;
    if (op == 5'b01111) return K_MWR;
    if (op == 5'b01101) return K_STK;
    if (op == 5'b11100) return K_JMP;
    if (op == 5'b11111) return K_HLT;
    return K_NOP;
  endfunction

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_pc"}, pc_o, 16'h0000);
    chk({tag, "_instr"}, instr_o, 16'h0000);
    chk({tag, "_carry"}, carry_o, 0);
    chk({tag, "_strobes"}, {mem_req_o, mem_we_o, reg_we_o, halted_o}, 0);
    chk({tag, "_addr"}, mem_addr_o, 16'h0000);
  endtask

  // Runs one instruction starting in FETCH; fw/mw are memory wait cycles
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic cout,
                           input logic [15:0] rn, input logic [15:0] ea, input logic run_end);
    int k;
    logic exp_we;
    for (int w = 0; w <= fw; w++) begin
      chk("fetch_state", state_o, 1);
      chk("fetch_bus", {mem_req_o, mem_we_o, reg_we_o}, 3'b100);
      chk("fetch_addr", mem_addr_o, m_pc);
      mem_ack_i   = (w == fw);
      mem_rdata_i = (w == fw) ? ins : 16'($urandom);
      step();
    end
    mem_ack_i = 1'b0;
    m_pc      = m_pc + 16'd1;
    m_instr   = ins;
    k = classify(ins);
    chk("exec_state", state_o, 2);
    chk("exec_instr", instr_o, m_instr);
    chk("exec_pc", pc_o, m_pc);
    chk("exec_req", mem_req_o, 0);
    alu_cout_i = cout;
    rn_val_i   = rn;
    addr_val_i = ea;
    if (k != K_MRD && k != K_MWR && k != K_STK) run_i = run_end;
    case (k)
      K_ALU: begin
        chk("alu_regwe", reg_we_o, 1);
        step();
        m_carry = cout;
      end
      K_MUL: begin
        chk("mul_exec_regwe", reg_we_o, 0);
        step();
        chk("mul_exec2_state", state_o, 3);
        chk("mul_exec2_regwe", reg_we_o, 1);
        chk("mul_exec2_carry_hold", carry_o, m_carry);
        step();
        m_carry = cout;
      end
      K_MRD, K_MWR, K_STK: begin
        chk("mem_exec_regwe", reg_we_o, 0);
        step();
        exp_we = (k == K_MWR) || (k == K_STK && ins[6]);
        for (int w = 0; w <= mw; w++) begin
          chk("mem_state", state_o, 4);
          chk("mem_bus", {mem_req_o, mem_we_o, reg_we_o}, {1'b1, exp_we, 1'b0});
          chk("mem_addr", mem_addr_o, ea);
          addr_val_i = 16'($urandom);
          alu_cout_i = ~cout;
          if (w == 0) run_i = run_end;
          mem_ack_i = (w == mw);
          step();
        end
        mem_ack_i = 1'b0;
        if (k != K_MWR) begin
          chk("wb_state", state_o, 5);
          chk("wb_bus", {mem_req_o, reg_we_o}, 2'b01);
          step();
        end
      end
      K_JMP: begin
        chk("jmp_regwe", reg_we_o, 0);
        step();
        m_pc = rn;
      end
      K_HLT: begin
        step();
        for (int c = 0; c < 20; c++) begin
          chk("halt_state", {state_o, halted_o}, {3'd6, 1'b1});
          chk("halt_bus", {mem_req_o, mem_we_o, reg_we_o}, 0);
          chk("halt_regs", {pc_o, instr_o}, {m_pc, m_instr});
          run_i       = 1'($urandom);
          mem_ack_i   = 1'($urandom);
          alu_cout_i  = 1'($urandom);
          rn_val_i    = 16'($urandom);
          step();
        end
        chk("halt_carry", carry_o, m_carry);
        mem_ack_i = 1'b0;
        return;
      end
      default: step();
    endcase
    chk("done_carry", carry_o, m_carry);
    chk("done_pc", pc_o, m_pc);
    chk("done_state", state_o, run_end ? 3'd1 : 3'd0);
  endtask

  task automatic restart();
    run_i = 1'b1;
    step();
  endtask

  initial begin
    logic [15:0] ins;
    logic        rend;
    resetn_i = 1'b0; run_i = 1'b0; mem_ack_i = 1'b0; alu_cout_i = 1'b0;
    mem_rdata_i = 16'h0; rn_val_i = 16'h0; addr_val_i = 16'h0;
    m_pc = 16'h0; m_instr = 16'h0; m_carry = 1'b0;
    step();
    step();
    chk_idle_reset("reset");
    resetn_i = 1'b1;
    step();
    chk_idle_reset("idle_norun");
    run_i = 1'b1;
    step();

    run_instr(16'h0800, 0, 0, 1'b1, 16'h0, 16'h0, 1'b1);
    chk("adr_carry_set", carry_o, 1);
    chk("adr_pc_one", pc_o, 16'h0001);
    run_instr(16'h4800, 3, 0, 1'b0, 16'h0, 16'h0, 1'b1);
    run_instr(16'h7800, 0, 2, 1'b1, 16'h0, 16'h1234, 1'b1);
    run_instr(16'h7000, 1, 0, 1'b1, 16'h0, 16'h2222, 1'b1);
    run_instr(16'h6840, 0, 1, 1'b0, 16'h0, 16'h0F00, 1'b1);
    run_instr(16'h6800, 2, 0, 1'b0, 16'h0, 16'h0EFF, 1'b1);
    run_instr(16'hE000, 0, 0, 1'b0, 16'hFFFF, 16'h0, 1'b1);
    run_instr(16'h0000, 0, 0, 1'b1, 16'h0, 16'h0, 1'b1);
    chk("pc_wrap", pc_o, 16'h0000);
    run_instr(16'hE000, 1, 0, 1'b0, 16'h0040, 16'h0, 1'b1);
    chk("jmr_fetch_addr", mem_addr_o, 16'h0040);
    run_instr(16'h1000, 0, 0, 1'b1, 16'h0, 16'h0, 1'b1);

    run_instr(16'h7800, 0, 3, 1'b0, 16'h0, 16'h5555, 1'b0);
    chk("run_drop_idle_bus", {mem_req_o, reg_we_o}, 0);
    step();
    chk("run_drop_stays_idle", state_o, 0);
    restart();

    chk("pre_reset_fetch", state_o, 1);
    step();
    resetn_i = 1'b0;
    step();
    resetn_i = 1'b1; run_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 16'hABCD;
    m_pc = 16'h0; m_instr = 16'h0; m_carry = 1'b0;
    chk_idle_reset("reset_mid_fetch");
    step();
    chk_idle_reset("late_ack_ignored");
    mem_ack_i = 1'b0;
    restart();

    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom);
      if (ins[15:11] == 5'b11111) ins[15] = 1'b0;
      rend = ($urandom_range(0, 4) != 0);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                16'($urandom), 16'($urandom), rend);
      if (!rend) restart();
    end

    run_instr(16'hF800, 1, 0, 1'b0, 16'h0, 16'h0, 1'b1);
    resetn_i = 1'b0;
    step();
    m_pc = 16'h0; m_instr = 16'h0; m_carry = 1'b0;
    chk_idle_reset("halt_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
